// File: rtl/iter_mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL/MLA write-back.
// Operands come from the register-file read ports. The product (plus the
// optional accumulate operand) is returned with its destination index and a
// one-cycle write strobe. The latency is fixed at W cycles, so the control
// unit can stall on BUSY without inspecting the operands.
module iter_mul_unit #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         RES,
  input  logic         START,
  input  logic [W-1:0] OpA,
  input  logic [W-1:0] OpB,
  input  logic [W-1:0] OpC,
  input  logic         ACC,
  input  logic [3:0]   DstAdd,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] Result,
  output logic [3:0]   WAdd,
  output logic         FlagN,
  output logic         FlagZ
);

  localparam int unsigned CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_mcand;
  logic [W-1:0]  r_mplier;
  logic [CW-1:0] r_count;

  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_result;
  logic [3:0]    r_wadd;
  logic          r_flag_n;
  logic          r_flag_z;

  logic          w_accept;
  logic          w_last;
  logic [W-1:0]  w_addend;
  logic [W-1:0]  w_acc_next;

  // The write-back cycle doubles as an idle cycle for acceptance, so a
  // request present during DONE is taken on the edge that leaves DONE.
  // This gives the one-op-per-(W+1)-cycles back-to-back rate.
  always_comb begin
    w_accept   = START && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_last     = (r_state == S_RUN) && (r_count == LAST_COUNT);
    w_addend   = r_mplier[0] ? r_mcand : '0;
    w_acc_next = r_acc + w_addend;
  end

  // State register.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (w_accept) begin
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand capture on accept, one shift-add step per RUN cycle.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_acc    <= ACC ? OpC : '0;
      r_mcand  <= OpA;
      r_mplier <= OpB;
      r_count  <= '0;
    end else if (r_state == S_RUN) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CW'(1);
    end
  end

  // Registered status. BUSY drops on the edge that performs the last step,
  // which is the same edge that raises DONE.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (r_state == S_RUN) && !w_last;
      r_done <= w_last;
    end
  end

  // Destination index is captured with the request; result and flags are
  // loaded on the last step and held until the next completion.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_result <= '0;
      r_wadd   <= '0;
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wadd <= DstAdd;
      end
      if (w_last) begin
        r_result <= w_acc_next;
        r_flag_n <= w_acc_next[W-1];
        r_flag_z <= (w_acc_next == '0);
      end
    end
  end

  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign Result = r_result;
  assign WAdd   = r_wadd;
  assign FlagN  = r_flag_n;
  assign FlagZ  = r_flag_z;

endmodule

// File: tb/tb_iter_mul_unit.sv
// Directed scoreboard bench for iter_mul_unit.
module tb_iter_mul_unit;

  localparam int unsigned W = 32;

  logic         CLK = 1'b0;
  logic         RES;
  logic         START;
  logic [W-1:0] OpA;
  logic [W-1:0] OpB;
  logic [W-1:0] OpC;
  logic         ACC;
  logic [3:0]   DstAdd;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] Result;
  logic [3:0]   WAdd;
  logic         FlagN;
  logic         FlagZ;

  iter_mul_unit #(.W(W)) dut (
    .CLK    (CLK),
    .RES    (RES),
    .START  (START),
    .OpA    (OpA),
    .OpB    (OpB),
    .OpC    (OpC),
    .ACC    (ACC),
    .DstAdd (DstAdd),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .Result (Result),
    .WAdd   (WAdd),
    .FlagN  (FlagN),
    .FlagZ  (FlagZ)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   wadd;
    logic         n;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic acc, input logic [3:0] dst);
    exp_t e;
    logic [W-1:0] prod;
    prod   = a * b;
    e.res  = prod + (acc ? c : '0);
    e.wadd = dst;
    e.n    = e.res[W-1];
    e.z    = (e.res == '0);
    sb.push_back(e);
  endtask

  // Called at a negedge: present a request for the following posedge.
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic acc, input logic [3:0] dst);
    OpA    = a;
    OpB    = b;
    OpC    = c;
    ACC    = acc;
    DstAdd = dst;
    START  = 1'b1;
    push_exp(a, b, c, acc, dst);
  endtask

  // s = index of the negedge (counted from the accept edge) where DONE was seen.
  task automatic wait_done(input int budget, output int s, output int nb);
    nb = 0;
    for (s = 0; s < budget; s++) begin
      @(negedge CLK);
      if (s == 0) START = 1'b0;
      if (DONE === 1'b1) break;
      if (BUSY === 1'b1) nb++;
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sb_avail"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_result"}, 64'(Result), 64'(e.res));
      check({tag, "_wadd"},   64'(WAdd),   64'(e.wadd));
      check({tag, "_flagN"},  64'(FlagN),  64'(e.n));
      check({tag, "_flagZ"},  64'(FlagZ),  64'(e.z));
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic acc, input logic [3:0] dst);
    int s;
    int nb;
    @(negedge CLK);
    drive_op(a, b, c, acc, dst);
    wait_done(W + 8, s, nb);
    check({tag, "_done_cycle"}, 64'(s), 64'(W));
    check({tag, "_busy_cycles"}, 64'(nb), 64'(W - 1));
    pop_check(tag);
    @(negedge CLK);
    check({tag, "_done_pulse"}, 64'(DONE), 64'd0);
  endtask

  initial begin
    int s;
    int nb;
    int n_done;

    RES    = 1'b1;
    START  = 1'b0;
    OpA    = '0;
    OpB    = '0;
    OpC    = '0;
    ACC    = 1'b0;
    DstAdd = '0;
    #12;
    check("reset_outputs", 64'({BUSY, DONE, Result, WAdd, FlagN, FlagZ}), 64'd0);
    @(negedge CLK);
    RES = 1'b0;

    // Plain multiply.
    run_op("mul_7x6", 32'd7, 32'd6, 32'd99, 1'b0, 4'd1);

    // Mid-cycle reset with no clock edge clears held outputs at once.
    @(negedge CLK);
    #2 RES = 1'b1;
    #1;
    check("async_reset_outputs", 64'({BUSY, DONE, Result, WAdd, FlagN, FlagZ}), 64'd0);
    @(negedge CLK);
    RES = 1'b0;

    // Accumulate with wrap-around.
    run_op("mla_wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 1'b1, 4'd3);
    // Negative-flag and zero-flag boundaries.
    run_op("neg_flag", 32'h8000_0000, 32'd1, 32'd0, 1'b0, 4'd9);
    run_op("zero_flag", 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 4'd15);
    // Zero multiplier still runs full length and returns C.
    run_op("b_zero_mla", 32'd123, 32'd0, 32'h0000_DEAD, 1'b1, 4'd6);
    // OpC ignored when ACC=0.
    run_op("acc_off", 32'd2, 32'd3, 32'd100, 1'b0, 4'd10);

    // START held through an op while operands change: only the captured
    // op is computed; the next one is taken on the edge leaving DONE.
    @(negedge CLK);
    drive_op(32'd3, 32'd5, 32'd0, 1'b0, 4'd2);
    nb = 0;
    for (s = 0; s < W + 8; s++) begin
      @(negedge CLK);
      if (DONE === 1'b1) break;
      if (BUSY === 1'b1) nb++;
      if (s == 3) begin
        OpA    = 32'd100;
        OpB    = 32'd200;
        OpC    = 32'd9;
        ACC    = 1'b1;
        DstAdd = 4'd7;
      end
    end
    check("hold_first_done_cycle", 64'(s), 64'(W));
    check("hold_first_busy_cycles", 64'(nb), 64'(W - 1));
    pop_check("hold_first");
    push_exp(32'd100, 32'd200, 32'd9, 1'b1, 4'd7);
    wait_done(W + 8, s, nb);
    check("hold_done_spacing", 64'(s + 1), 64'(W + 1));
    check("hold_second_busy_cycles", 64'(nb), 64'(W - 1));
    pop_check("hold_second");
    @(negedge CLK);
    check("hold_done_pulse", 64'(DONE), 64'd0);

    // Reset during RUN at count=10 drops BUSY at once, produces no DONE.
    @(negedge CLK);
    drive_op(32'd9, 32'd9, 32'd0, 1'b0, 4'd4);
    for (int i = 0; i <= 10; i++) begin
      @(negedge CLK);
      if (i == 0) START = 1'b0;
    end
    check("busy_before_reset", 64'(BUSY), 64'd1);
    #2 RES = 1'b1;
    #1;
    check("run_reset_outputs", 64'({BUSY, DONE, Result, WAdd, FlagN, FlagZ}), 64'd0);
    sb.delete();
    @(negedge CLK);
    RES = 1'b0;
    n_done = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1) n_done++;
    end
    check("no_done_after_reset", 64'(n_done), 64'd0);
    run_op("after_reset", 32'd12, 32'd11, 32'd0, 1'b0, 4'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
